// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and helpers for the unified memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        RSP_NONE  = 2'd0,
        RSP_INSTR = 2'd1,
        RSP_DRD   = 2'd2,
        RSP_DWR   = 2'd3
    } rsp_owner_e;

    // Byte address to RAM word index; callers truncate to their RAM depth.
    function automatic logic [31:0] byte_to_word(input logic [31:0] byte_addr);
        return byte_addr >> 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module      : arb_starve_ctr
// Description : Saturating count of consecutive cycles a pending fetch lost.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_starve_ctr #(
    parameter int MaxIStarve = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ireq_valid_i,
    input  logic igrant_i,
    output logic force_instr_o
);

    localparam int c_cnt_w = $clog2(MaxIStarve + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(MaxIStarve);

    logic [c_cnt_w-1:0] r_starve_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_starve_cnt <= '0;
        end else if (!ireq_valid_i || igrant_i) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != c_cnt_max) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    assign force_instr_o = (r_starve_cnt == c_cnt_max);

endmodule
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : unified_mem_arbiter
// Description : Shares one single-port RAM between fetch and data requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLen       = 32,
    parameter int AddrWidth  = 10,
    parameter int MaxIStarve = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ireq_valid_i,
    output logic                 ireq_ready_o,
    input  logic [AddrWidth-1:0] ireq_addr_i,
    output logic                 irsp_valid_o,
    output logic [XLen-1:0]      irsp_rdata_o,
    input  logic                 dreq_valid_i,
    output logic                 dreq_ready_o,
    input  logic [AddrWidth-1:0] dreq_addr_i,
    input  logic                 dreq_we_i,
    input  logic [XLen-1:0]      dreq_wdata_i,
    output logic                 drsp_valid_o,
    output logic [XLen-1:0]      drsp_rdata_o,
    output logic [AddrWidth-3:0] mem_addr_o,
    output logic                 mem_we_o,
    output logic [XLen-1:0]      mem_wdata_o,
    input  logic [XLen-1:0]      mem_rdata_i
);

    logic                 w_force_instr;
    logic                 w_igrant;
    logic                 w_dgrant;
    logic [AddrWidth-1:0] w_addr_sel;
    rsp_owner_e           r_rsp_q;
    rsp_owner_e           w_rsp_d;

    arb_starve_ctr #(
        .MaxIStarve (MaxIStarve)
    ) u_starve_ctr (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .ireq_valid_i  (ireq_valid_i),
        .igrant_i      (w_igrant),
        .force_instr_o (w_force_instr)
    );

    // Data wins by default; fetch wins when alone or once it has starved.
    always_comb begin
        w_igrant = 1'b0;
        w_dgrant = 1'b0;
        if (!rst_i) begin
            w_igrant = ireq_valid_i && (!dreq_valid_i || w_force_instr);
            w_dgrant = dreq_valid_i && !w_igrant;
        end
    end

    assign ireq_ready_o = w_igrant;
    assign dreq_ready_o = w_dgrant;

    always_comb begin
        w_addr_sel = '0;
        if (w_igrant) begin
            w_addr_sel = ireq_addr_i;
        end else if (w_dgrant) begin
            w_addr_sel = dreq_addr_i;
        end
    end

    assign mem_addr_o  = (AddrWidth-2)'(byte_to_word(32'(w_addr_sel)));
    assign mem_we_o    = w_dgrant && dreq_we_i;
    assign mem_wdata_o = dreq_wdata_i;

    always_comb begin
        w_rsp_d = RSP_NONE;
        if (w_igrant) begin
            w_rsp_d = RSP_INSTR;
        end else if (w_dgrant) begin
            w_rsp_d = dreq_we_i ? RSP_DWR : RSP_DRD;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rsp_q <= RSP_NONE;
        end else begin
            r_rsp_q <= w_rsp_d;
        end
    end

    // Gating with rst_i drops a response that would land in a reset cycle.
    assign irsp_valid_o = !rst_i && (r_rsp_q == RSP_INSTR);
    assign drsp_valid_o = !rst_i && ((r_rsp_q == RSP_DRD) || (r_rsp_q == RSP_DWR));
    assign irsp_rdata_o = irsp_valid_o ? mem_rdata_i : '0;
    assign drsp_rdata_o = (!rst_i && (r_rsp_q == RSP_DRD)) ? mem_rdata_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_unified_mem_arbiter
// Description : Directed and randomized checks of unified_mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unified_mem_arbiter;

    localparam int MAX_STARVE = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ireq_valid_i, ireq_ready_o, irsp_valid_o;
    logic [9:0]  ireq_addr_i;
    logic [31:0] irsp_rdata_o;
    logic        dreq_valid_i, dreq_ready_o, dreq_we_i, drsp_valid_o;
    logic [9:0]  dreq_addr_i;
    logic [31:0] dreq_wdata_i, drsp_rdata_o;
    logic [7:0]  mem_addr_o;
    logic        mem_we_o;
    logic [31:0] mem_wdata_o, mem_rdata_i;

    logic [31:0] ram  [0:255];
    logic [31:0] gold [0:255];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    unified_mem_arbiter #(
        .XLen       (32),
        .AddrWidth  (10),
        .MaxIStarve (MAX_STARVE)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .ireq_valid_i (ireq_valid_i),
        .ireq_ready_o (ireq_ready_o),
        .ireq_addr_i  (ireq_addr_i),
        .irsp_valid_o (irsp_valid_o),
        .irsp_rdata_o (irsp_rdata_o),
        .dreq_valid_i (dreq_valid_i),
        .dreq_ready_o (dreq_ready_o),
        .dreq_addr_i  (dreq_addr_i),
        .dreq_we_i    (dreq_we_i),
        .dreq_wdata_i (dreq_wdata_i),
        .drsp_valid_o (drsp_valid_o),
        .drsp_rdata_o (drsp_rdata_o),
        .mem_addr_o   (mem_addr_o),
        .mem_we_o     (mem_we_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i)
    );

    // Single-port RAM with one-cycle read latency, write-first.
    always @(posedge clk_i) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
        mem_rdata_i <= mem_we_o ? mem_wdata_o : ram[mem_addr_o];
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [9:0] ia, input logic dv,
                         input logic [9:0] da, input logic we, input logic [31:0] wd);
        ireq_valid_i = iv; ireq_addr_i = ia;
        dreq_valid_i = dv; dreq_addr_i = da; dreq_we_i = we; dreq_wdata_i = wd;
    endtask

    task automatic preload(input int word, input logic [31:0] data);
        pl_en = 1'b1; pl_addr = 8'(word); pl_data = data;
        gold[word] = data;
        tick;
        pl_en = 1'b0;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        drive(1'b1, 10'h004, 1'b1, 10'h100, 1'b1, 32'hA5A5A5A5);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            checks++;
            if (ireq_ready_o !== 1'b0) begin errors++; $display("FAIL reset_iready: got %b want 0", ireq_ready_o); end
            checks++;
            if (dreq_ready_o !== 1'b0) begin errors++; $display("FAIL reset_dready: got %b want 0", dreq_ready_o); end
            checks++;
            if (mem_we_o !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we_o); end
            tick;
        end
        rst_i = 1'b0;
        drive(1'b0, '0, 1'b0, '0, 1'b0, '0);
        @(negedge clk_i);
        checks++;
        if ({irsp_valid_o, drsp_valid_o, irsp_rdata_o, drsp_rdata_o} !== 66'h0) begin
            errors++;
            $display("FAIL reset_rsp: got iv=%b dv=%b ir=%h dr=%h want all 0",
                     irsp_valid_o, drsp_valid_o, irsp_rdata_o, drsp_rdata_o);
        end
        tick;
    endtask

    task automatic test_fetch_only;
        preload(0, 32'h00500093);
        preload(1, 32'h00100113);
        preload(2, 32'h002081b3);
        for (int k = 0; k < 4; k++) begin
            drive(k < 3, 10'(4 * k), 1'b0, '0, 1'b0, '0);
            @(negedge clk_i);
            if (k < 3) begin
                checks++;
                if (ireq_ready_o !== 1'b1) begin errors++; $display("FAIL fetch_ready[%0d]: got %b want 1", k, ireq_ready_o); end
            end
            if (k > 0) begin
                checks++;
                if (irsp_valid_o !== 1'b1 || irsp_rdata_o !== gold[k-1]) begin
                    errors++;
                    $display("FAIL fetch_rsp[%0d]: got v=%b d=%h want v=1 d=%h", k, irsp_valid_o, irsp_rdata_o, gold[k-1]);
                end
            end
            checks++;
            if (drsp_valid_o !== 1'b0) begin errors++; $display("FAIL fetch_drsp[%0d]: got %b want 0", k, drsp_valid_o); end
            tick;
        end
    endtask

    task automatic test_data_priority;
        preload(64, 32'hDEADBEEF);
        preload(3, 32'h0000_0013);
        drive(1'b1, 10'h00C, 1'b1, 10'h100, 1'b0, '0);
        @(negedge clk_i);
        checks++;
        if ({ireq_ready_o, dreq_ready_o} !== 2'b01) begin
            errors++; $display("FAIL prio_grant: got i=%b d=%b want i=0 d=1", ireq_ready_o, dreq_ready_o);
        end
        tick;
        drive(1'b1, 10'h00C, 1'b0, '0, 1'b0, '0);
        @(negedge clk_i);
        checks++;
        if (ireq_ready_o !== 1'b1) begin errors++; $display("FAIL prio_fetch_next: got %b want 1", ireq_ready_o); end
        checks++;
        if (drsp_valid_o !== 1'b1 || drsp_rdata_o !== 32'hDEADBEEF || irsp_rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL prio_drsp: got v=%b d=%h ir=%h want v=1 d=deadbeef ir=0", drsp_valid_o, drsp_rdata_o, irsp_rdata_o);
        end
        tick;
        drive(1'b0, '0, 1'b0, '0, 1'b0, '0);
        @(negedge clk_i);
        checks++;
        if (irsp_valid_o !== 1'b1 || irsp_rdata_o !== gold[3] || drsp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL prio_irsp: got v=%b d=%h dv=%b want v=1 d=%h dv=0", irsp_valid_o, irsp_rdata_o, drsp_valid_o, gold[3]);
        end
        tick;
    endtask

    task automatic test_starvation;
        int         dword = 64;
        int         prev  = 0;   // 0 none, 1 fetch, 2 data read
        int         prev_word = 0;
        logic       exp_i;
        for (int k = 0; k < 8; k++) begin
            drive(k < 7, 10'h010, k < 7, 10'(dword * 4), 1'b0, '0);
            exp_i = (k == MAX_STARVE);
            @(negedge clk_i);
            if (k < 7) begin
                checks++;
                if ({ireq_ready_o, dreq_ready_o} !== {exp_i, !exp_i}) begin
                    errors++;
                    $display("FAIL starve_grant[%0d]: got i=%b d=%b want i=%b d=%b", k, ireq_ready_o, dreq_ready_o, exp_i, !exp_i);
                end
            end
            if (k > 0) begin
                checks++;
                if (irsp_valid_o !== (prev == 1) || drsp_valid_o !== (prev == 2) ||
                    (prev == 2 && drsp_rdata_o !== gold[prev_word]) ||
                    (prev == 1 && irsp_rdata_o !== gold[4])) begin
                    errors++;
                    $display("FAIL starve_rsp[%0d]: got iv=%b dv=%b ir=%h dr=%h want kind=%0d", k,
                             irsp_valid_o, drsp_valid_o, irsp_rdata_o, drsp_rdata_o, prev);
                end
            end
            if (k < 7) begin
                prev      = exp_i ? 1 : 2;
                prev_word = dword;
                if (!exp_i) dword++;
            end
            tick;
        end
    endtask

    task automatic test_write_then_read;
        drive(1'b0, '0, 1'b1, 10'h200, 1'b1, 32'h12345678);
        @(negedge clk_i);
        checks++;
        if (dreq_ready_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 8'h80 || mem_wdata_o !== 32'h12345678) begin
            errors++;
            $display("FAIL wr_drive: got rdy=%b we=%b a=%h wd=%h want 1 1 80 12345678", dreq_ready_o, mem_we_o, mem_addr_o, mem_wdata_o);
        end
        gold[128] = 32'h12345678;
        tick;
        drive(1'b0, '0, 1'b1, 10'h200, 1'b0, 32'hFFFF0000);
        @(negedge clk_i);
        checks++;
        if (mem_we_o !== 1'b0) begin errors++; $display("FAIL rd_mem_we: got %b want 0", mem_we_o); end
        checks++;
        if (drsp_valid_o !== 1'b1 || drsp_rdata_o !== 32'h0) begin
            errors++; $display("FAIL wr_ack: got v=%b d=%h want v=1 d=0", drsp_valid_o, drsp_rdata_o);
        end
        tick;
        drive(1'b0, '0, 1'b0, '0, 1'b0, '0);
        @(negedge clk_i);
        checks++;
        if (drsp_valid_o !== 1'b1 || drsp_rdata_o !== 32'h12345678 || mem_we_o !== 1'b0) begin
            errors++;
            $display("FAIL rd_after_wr: got v=%b d=%h we=%b want v=1 d=12345678 we=0", drsp_valid_o, drsp_rdata_o, mem_we_o);
        end
        tick;
    endtask

    task automatic test_reset_mid_op;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 10'h020, 1'b1, 10'h300, 1'b0, '0);
            @(negedge clk_i);
            checks++;
            if (dreq_ready_o !== 1'b1) begin errors++; $display("FAIL rmid_pre[%0d]: got %b want 1", k, dreq_ready_o); end
            tick;
        end
        drive(1'b1, 10'h020, 1'b0, '0, 1'b0, '0);
        @(negedge clk_i);
        checks++;
        if (ireq_ready_o !== 1'b1) begin errors++; $display("FAIL rmid_grant: got %b want 1", ireq_ready_o); end
        tick;
        rst_i = 1'b1;
        drive(1'b1, 10'h024, 1'b1, 10'h304, 1'b1, 32'h0BAD0BAD);
        @(negedge clk_i);
        checks++;
        if ({ireq_ready_o, dreq_ready_o, mem_we_o, irsp_valid_o, drsp_valid_o} !== 5'b0) begin
            errors++;
            $display("FAIL rmid_in_reset: got ir=%b dr=%b we=%b iv=%b dv=%b want all 0",
                     ireq_ready_o, dreq_ready_o, mem_we_o, irsp_valid_o, drsp_valid_o);
        end
        tick;
        rst_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 10'h024, 1'b1, 10'h304, 1'b0, '0);
            @(negedge clk_i);
            checks++;
            if ({ireq_ready_o, dreq_ready_o} !== {k == MAX_STARVE, k != MAX_STARVE}) begin
                errors++;
                $display("FAIL rmid_post[%0d]: got i=%b d=%b want i=%b", k, ireq_ready_o, dreq_ready_o, k == MAX_STARVE);
            end
            if (k == 0) begin
                checks++;
                if (irsp_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_dropped: got %b want 0", irsp_valid_o); end
            end
            tick;
        end
        drive(1'b0, '0, 1'b0, '0, 1'b0, '0);
        tick;
    endtask

    task automatic test_idle;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 10'($urandom), 1'b0, 10'($urandom), 1'b1, $urandom);
            @(negedge clk_i);
            checks++;
            if (mem_we_o !== 1'b0 || mem_addr_o !== 8'h0 || ireq_ready_o !== 1'b0 || dreq_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL idle_mem[%0d]: got we=%b a=%h ir=%b dr=%b want 0 0 0 0", k, mem_we_o, mem_addr_o, ireq_ready_o, dreq_ready_o);
            end
            if (k > 0) begin
                checks++;
                if (irsp_valid_o !== 1'b0 || drsp_valid_o !== 1'b0) begin
                    errors++; $display("FAIL idle_rsp[%0d]: got iv=%b dv=%b want 0 0", k, irsp_valid_o, drsp_valid_o);
                end
            end
            tick;
        end
    endtask

    // Reference model: count consecutive fetch losses, queue one pending response.
    task automatic test_random;
        logic        iv = 1'b0, dv = 1'b0, we = 1'b0, rst = 1'b0;
        logic [9:0]  ia = '0, da = '0;
        logic [31:0] wd = '0;
        logic        ig = 1'b0, dg = 1'b0;
        int          losses = 0;
        int          pend = 0;     // 0 none, 1 fetch, 2 data read, 3 write ack
        logic [31:0] pend_data = '0;
        logic [7:0]  exp_addr;
        for (int c = 0; c < 600; c++) begin
            if (!(iv && !ig)) begin iv = ($urandom_range(0, 3) != 0); ia = 10'($urandom); end
            if (!(dv && !dg)) begin
                dv = ($urandom_range(0, 3) != 0); da = 10'($urandom);
                we = 1'($urandom); wd = $urandom;
            end
            rst = ($urandom_range(0, 39) == 0);
            rst_i = rst;
            drive(iv, ia, dv, da, we, wd);
            ig = !rst && iv && (!dv || losses >= MAX_STARVE);
            dg = !rst && dv && !ig;
            exp_addr = ig ? ia[9:2] : (dg ? da[9:2] : 8'h0);
            @(negedge clk_i);
            checks++;
            if (ireq_ready_o !== ig || dreq_ready_o !== dg) begin
                errors++; $display("FAIL rnd_grant[%0d]: got i=%b d=%b want i=%b d=%b", c, ireq_ready_o, dreq_ready_o, ig, dg);
            end
            checks++;
            if (mem_we_o !== (dg && we) || mem_addr_o !== exp_addr || (dg && we && mem_wdata_o !== wd)) begin
                errors++;
                $display("FAIL rnd_mem[%0d]: got we=%b a=%h wd=%h want we=%b a=%h wd=%h", c,
                         mem_we_o, mem_addr_o, mem_wdata_o, dg && we, exp_addr, wd);
            end
            checks++;
            if (irsp_valid_o !== (!rst && pend == 1) || drsp_valid_o !== (!rst && pend >= 2) ||
                irsp_rdata_o !== ((!rst && pend == 1) ? pend_data : 32'h0) ||
                drsp_rdata_o !== ((!rst && pend == 2) ? pend_data : 32'h0)) begin
                errors++;
                $display("FAIL rnd_rsp[%0d]: got iv=%b ir=%h dv=%b dr=%h want kind=%0d data=%h rst=%b", c,
                         irsp_valid_o, irsp_rdata_o, drsp_valid_o, drsp_rdata_o, pend, pend_data, rst);
            end
            if (ig) begin
                pend = 1; pend_data = gold[ia[9:2]];
            end else if (dg && we) begin
                pend = 3; pend_data = 32'h0; gold[da[9:2]] = wd;
            end else if (dg) begin
                pend = 2; pend_data = gold[da[9:2]];
            end else begin
                pend = 0;
            end
            if (rst) pend = 0;
            if (rst || !iv || ig) losses = 0;
            else if (losses < MAX_STARVE) losses++;
            tick;
        end
        rst_i = 1'b0;
        drive(1'b0, '0, 1'b0, '0, 1'b0, '0);
        tick;
    endtask

    initial begin
        rst_i = 1'b1;
        drive(1'b0, '0, 1'b0, '0, 1'b0, '0);
        for (int w = 0; w < 256; w++) preload(w, $urandom);
        test_reset();
        test_fetch_only();
        test_data_priority();
        test_starvation();
        test_write_then_read();
        test_reset_mid_op();
        test_idle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares one single-port synchronous RAM (1-cycle read latency) between the pipelined core's instruction-fetch port and its data port. Each requester uses a valid/ready request handshake and receives a one-cycle response pulse. Data accesses have default priority. An instruction starvation counter guarantees forward progress for fetch. The block sits between riscv_pl and a single ram instance, replacing the separate pmem/dmem pair.

Parameters:
XLen, 32, data/instruction word width
AddrWidth, 10, byte-address width seen by requesters; the RAM word address is [AddrWidth-1:2]
MaxIStarve, 4, consecutive cycles a pending fetch may lose before it is forced to win (>=1)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active high
ireq_valid_i  in  1  fetch request valid
ireq_ready_o  out  1  fetch request granted this cycle
ireq_addr_i  in  AddrWidth  fetch byte address
irsp_valid_o  out  1  fetch data valid (one cycle after grant)
irsp_rdata_o  out  XLen  fetched instruction
dreq_valid_i  in  1  data request valid
dreq_ready_o  out  1  data request granted this cycle
dreq_addr_i  in  AddrWidth  data byte address
dreq_we_i  in  1  1 = write, 0 = read
dreq_wdata_i  in  XLen  write data
drsp_valid_o  out  1  data response (read data or write ack)
drsp_rdata_o  out  XLen  read data; 0 for write acks
mem_addr_o  out  AddrWidth-2  RAM word address
mem_we_o  out  1  RAM write enable
mem_wdata_o  out  XLen  RAM write data
mem_rdata_i  in  XLen  RAM read data, valid the cycle after the address is presented

Behaviour:
- Handshake: a request transfers when valid && ready in the same cycle. Requester holds addr/we/wdata stable while valid && !ready. Ready is combinational from both valids and the starvation state. At most one grant per cycle.
- Arbitration, evaluated each cycle:
  - Only one valid: that port is granted.
  - Both valid and starve_cnt < MaxIStarve: data is granted.
  - Both valid and starve_cnt == MaxIStarve: fetch is granted.
- starve_cnt (width $clog2(MaxIStarve+1)):
  - Increments when ireq_valid_i && !ireq_ready_o.
  - Clears on a fetch grant or when ireq_valid_i = 0.
  - Saturates at MaxIStarve.
- RAM drive, combinational from the grant:
  - mem_addr_o = granted addr[AddrWidth-1:2].
  - mem_we_o = data grant && dreq_we_i.
  - mem_wdata_o = dreq_wdata_i.
  - No grant: mem_addr_o = 0, mem_we_o = 0.
  - Low two address bits are ignored; no misalignment trap.
- Response owner register rsp_q ∈ {RSP_NONE, RSP_INSTR, RSP_DRD, RSP_DWR}, loaded each cycle from the grant.
  - irsp_valid_o = (rsp_q == RSP_INSTR).
  - drsp_valid_o = (rsp_q == RSP_DRD || rsp_q == RSP_DWR).
  - Read data is routed from mem_rdata_i to the owning port; the non-owning rdata output is 0.
  - Latency is exactly 1 cycle, grant to response. Throughput is one access per cycle, with no bubbles between back-to-back grants.
  - Responses have no backpressure; requesters always accept.
- Write then read to the same word in consecutive cycles returns the new data (RAM write-first ordering).
- Reset, synchronous: rsp_q = RSP_NONE, starve_cnt = 0. All response outputs are 0 in the cycle after rst_i is sampled high. While rst_i = 1, both ready outputs are 0 and mem_we_o = 0.
- Reset mid-operation: a response pending for the cycle after reset is dropped (not delivered).

Decomposition:
- Package mem_arb_pkg: rsp_owner_e enum (RSP_NONE, RSP_INSTR, RSP_DRD, RSP_DWR) and a helper function for byte-to-word address conversion.
- Sub-module arb_starve_ctr: the saturating counter, exposing a force_instr_o flag. The arbiter mux, owner register and response routing stay in the top.

Test Plan:
- Fetch only: ireq_valid=1 at 0x000, 0x004, 0x008 on consecutive cycles, RAM preloaded 0x00500093, 0x00100113, 0x002081b3 -> ireq_ready=1 every cycle; irsp_valid one cycle later with those words in order; drsp_valid=0 throughout.
- Data priority: both valid for 2 cycles, dreq read 0x100 containing 0xDEADBEEF -> dreq granted first; drsp_rdata=0xDEADBEEF next cycle; fetch granted in the following cycle.
- Starvation: MaxIStarve=4, dreq_valid held 1 with back-to-back reads, ireq_valid held 1 -> data wins 4 cycles; fetch granted on the 5th; starve_cnt returns to 0 and data wins again on the 6th.
- Write then read: write 0x12345678 to 0x200, then read 0x200 the next cycle -> write-ack drsp_valid with rdata=0; then drsp_rdata=0x12345678; mem_we_o high only in the write cycle.
- Reset mid-op: fetch granted at cycle N, rst_i=1 at cycle N+1 -> irsp_valid stays 0, ready outputs 0, starve_cnt=0; normal grant on the first cycle after rst_i falls.
- Idle: both valids 0 -> mem_we_o=0, mem_addr_o=0, no response pulses.
